// File: rtl/median_scan_ctrl_if.sv
// Handshake bundle between median_scan_ctrl and its host, getWindow, sorter and writer.
// The master modport is the sequencer side; slave is the surrounding environment.
interface median_scan_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] xCenter;
    logic [7:0] yCenter;
    logic       startGet;
    logic       windowOut;
    logic       medianStart;
    logic       medianDone;
    logic       wrValid;
    logic       wrReady;
    logic       busy;
    logic       frameDone;

    modport master (
        input  start, abort, windowOut, medianDone, wrReady,
        output xCenter, yCenter, startGet, medianStart, wrValid, busy, frameDone
    );

    modport slave (
        output start, abort, windowOut, medianDone, wrReady,
        input  xCenter, yCenter, startGet, medianStart, wrValid, busy, frameDone
    );
endinterface

// File: rtl/median_scan_ctrl.sv
// Frame sequencer for the median filter: walks every interior pixel in raster order,
// launches getWindow, counts its nine coordinates, runs the sorter and hands off to the writer.
module median_scan_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    median_scan_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_COLLECT, S_MSTART, S_MWAIT, S_WRITE, S_NEXT, S_DONE
    } state_t;

    localparam logic [7:0] X_LAST = 8'(IMG_W - 2);
    localparam logic [7:0] Y_LAST = 8'(IMG_H - 2);

    state_t     r_state;
    logic [3:0] r_win_cnt;
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic       r_start_get;
    logic       r_med_start;
    logic       r_wr_valid;
    logic       r_busy;
    logic       r_frame_done;

    assign bus.xCenter     = r_x;
    assign bus.yCenter     = r_y;
    assign bus.startGet    = r_start_get;
    assign bus.medianStart = r_med_start;
    assign bus.wrValid     = r_wr_valid;
    assign bus.busy        = r_busy;
    assign bus.frameDone   = r_frame_done;

    // State machine; every output is a register set on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_win_cnt    <= 4'd0;
            r_x          <= 8'd0;
            r_y          <= 8'd0;
            r_start_get  <= 1'b0;
            r_med_start  <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (bus.abort && (r_state != S_IDLE)) begin
            // Abort outranks every transition; coordinates are left as they were.
            r_state      <= S_IDLE;
            r_start_get  <= 1'b0;
            r_med_start  <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_start_get  <= 1'b0;
            r_med_start  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_x         <= 8'd1;
                        r_y         <= 8'd1;
                        r_start_get <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_win_cnt <= 4'd0;
                    r_state   <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (bus.windowOut) begin
                        if (r_win_cnt >= 4'd8) begin
                            r_win_cnt   <= 4'd9;
                            r_med_start <= 1'b1;
                            r_state     <= S_MSTART;
                        end else begin
                            r_win_cnt <= r_win_cnt + 4'd1;
                        end
                    end
                end
                S_MSTART: begin
                    r_state <= S_MWAIT;
                end
                S_MWAIT: begin
                    if (bus.medianDone) begin
                        r_wr_valid <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.wrReady) begin
                        r_wr_valid <= 1'b0;
                        r_state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_x < X_LAST) begin
                        r_x         <= r_x + 8'd1;
                        r_start_get <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (r_y < Y_LAST) begin
                        r_x         <= 8'd1;
                        r_y         <= r_y + 8'd1;
                        r_start_get <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wr_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed bench for median_scan_ctrl: a 5x4 instance for the main scenarios and a 3x3 instance
// for the single-pixel frame.
module tb_median_scan_ctrl;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_sg = 0;
    int   n_ms = 0;
    int   n_fd = 0;

    always #5 clk = ~clk;

    median_scan_ctrl_if ifa ();
    median_scan_ctrl_if ifb ();

    median_scan_ctrl #(.IMG_W(5), .IMG_H(4)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa.master));
    median_scan_ctrl #(.IMG_W(3), .IMG_H(3)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb.master));

    // Pulse counters; a pulse visible during a cycle is counted at the edge that ends it.
    always @(posedge clk) begin
        if (ifa.startGet === 1'b1)    n_sg <= n_sg + 1;
        if (ifa.medianStart === 1'b1) n_ms <= n_ms + 1;
        if (ifa.frameDone === 1'b1)   n_fd <= n_fd + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one pixel of dut_a starting at its ISSUE cycle.
    // stop: 0 = complete, 1 = abort in MWAIT, 2 = start-while-busy then reset in WRITE.
    task automatic pixel_a(input int k, input int stall, input bit noise, input int stop);
        logic [7:0] ex;
        logic [7:0] ey;
        int vcnt;
        ex = 8'(1 + k % 3);
        ey = 8'(1 + k / 3);
        check_eq("issue_sg", 32'(ifa.startGet), 32'd1);
        check_eq("issue_x", 32'(ifa.xCenter), 32'(ex));
        check_eq("issue_y", 32'(ifa.yCenter), 32'(ey));
        ifa.windowOut = noise;
        if (stop == 2) ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        check_eq("collect_sg", 32'(ifa.startGet), 32'd0);
        ifa.windowOut  = 1'b1;
        ifa.medianDone = noise;
        repeat (8) @(negedge clk);
        check_eq("ms_after8", 32'(ifa.medianStart), 32'd0);
        @(negedge clk);
        check_eq("ms_after9", 32'(ifa.medianStart), 32'd1);
        ifa.windowOut  = noise;
        ifa.medianDone = 1'b0;
        @(negedge clk);
        check_eq("mwait_ms", 32'(ifa.medianStart), 32'd0);
        check_eq("mwait_wv", 32'(ifa.wrValid), 32'd0);
        if (stop == 1) begin
            ifa.abort = 1'b1;
            @(negedge clk);
            ifa.abort     = 1'b0;
            ifa.windowOut = 1'b0;
            check_eq("abort_busy", 32'(ifa.busy), 32'd0);
            check_eq("abort_wv", 32'(ifa.wrValid), 32'd0);
            check_eq("abort_sg", 32'(ifa.startGet), 32'd0);
            return;
        end
        ifa.medianDone = 1'b1;
        @(negedge clk);
        ifa.medianDone = 1'b0;
        ifa.windowOut  = 1'b0;
        check_eq("write_wv", 32'(ifa.wrValid), 32'd1);
        check_eq("write_x", 32'(ifa.xCenter), 32'(ex));
        check_eq("write_y", 32'(ifa.yCenter), 32'(ey));
        if (stop == 2) begin
            rst_a = 1'b1;
            @(negedge clk);
            rst_a = 1'b0;
            check_eq("rst_x", 32'(ifa.xCenter), 32'd0);
            check_eq("rst_y", 32'(ifa.yCenter), 32'd0);
            check_eq("rst_busy", 32'(ifa.busy), 32'd0);
            check_eq("rst_wv", 32'(ifa.wrValid), 32'd0);
            check_eq("rst_pulses", 32'({ifa.startGet, ifa.medianStart, ifa.frameDone}), 32'd0);
            return;
        end
        vcnt = 1;
        repeat (stall) begin
            @(negedge clk);
            if (ifa.wrValid === 1'b1) vcnt++;
            check_eq("stall_xy", 32'({ifa.xCenter, ifa.yCenter}), 32'({ex, ey}));
            check_eq("stall_sg", 32'(ifa.startGet), 32'd0);
        end
        check_eq("wv_cycles", 32'(vcnt), 32'(1 + stall));
        ifa.wrReady = 1'b1;
        @(negedge clk);
        ifa.wrReady = 1'b0;
        check_eq("next_wv", 32'(ifa.wrValid), 32'd0);
        check_eq("next_sg", 32'(ifa.startGet), 32'd0);
        check_eq("next_busy", 32'(ifa.busy), 32'd1);
        @(negedge clk);
    endtask

    task automatic start_a();
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        check_eq("start_busy", 32'(ifa.busy), 32'd1);
    endtask

    task automatic run_frame_a(input int stall_k, input int stall, input bit noise);
        int sg0;
        int ms0;
        int fd0;
        sg0 = n_sg;
        ms0 = n_ms;
        fd0 = n_fd;
        if (noise) begin
            ifa.windowOut = 1'b1;
            @(negedge clk);
            ifa.windowOut = 1'b0;
            check_eq("idle_noise_busy", 32'(ifa.busy), 32'd0);
        end
        start_a();
        for (int k = 0; k < 6; k++) pixel_a(k, (k == stall_k) ? stall : 0, noise, 0);
        check_eq("done_fd", 32'(ifa.frameDone), 32'd1);
        check_eq("done_sg", 32'(ifa.startGet), 32'd0);
        check_eq("done_busy", 32'(ifa.busy), 32'd1);
        @(negedge clk);
        check_eq("post_busy", 32'(ifa.busy), 32'd0);
        check_eq("post_fd", 32'(ifa.frameDone), 32'd0);
        check_eq("post_xy", 32'({ifa.xCenter, ifa.yCenter}), 32'({8'd3, 8'd2}));
        check_eq("cnt_sg", 32'(n_sg - sg0), 32'd6);
        check_eq("cnt_ms", 32'(n_ms - ms0), 32'd6);
        check_eq("cnt_fd", 32'(n_fd - fd0), 32'd1);
    endtask

    initial begin
        int sg0;
        int fd0;
        {ifa.start, ifa.abort, ifa.windowOut, ifa.medianDone, ifa.wrReady} = 5'b0;
        {ifb.start, ifb.abort, ifb.windowOut, ifb.medianDone, ifb.wrReady} = 5'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check_eq("reset_xy", 32'({ifa.xCenter, ifa.yCenter}), 32'd0);
        check_eq("reset_outs", 32'({ifa.startGet, ifa.medianStart, ifa.wrValid, ifa.busy, ifa.frameDone}), 32'd0);
        check_eq("reset_b_busy", 32'(ifb.busy), 32'd0);

        // start and abort together in IDLE: abort wins
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        check_eq("startabort_busy", 32'(ifa.busy), 32'd0);
        check_eq("startabort_sg", 32'(ifa.startGet), 32'd0);

        run_frame_a(-1, 0, 1'b0);
        run_frame_a(1, 7, 1'b0);
        run_frame_a(-1, 0, 1'b1);

        // abort in MWAIT at (2,1), then a clean restart
        fd0 = n_fd;
        start_a();
        pixel_a(0, 0, 1'b0, 0);
        pixel_a(1, 0, 1'b0, 1);
        repeat (5) @(negedge clk);
        check_eq("abort_idle_busy", 32'(ifa.busy), 32'd0);
        check_eq("abort_no_fd", 32'(n_fd - fd0), 32'd0);
        run_frame_a(-1, 0, 1'b0);

        // reset during WRITE with a start while busy
        sg0 = n_sg;
        start_a();
        pixel_a(0, 0, 1'b0, 2);
        repeat (10) @(negedge clk);
        check_eq("rst_stays_idle", 32'(ifa.busy), 32'd0);
        check_eq("rst_no_frame", 32'(n_sg - sg0), 32'd1);

        // 3x3 frame: a single interior pixel
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        check_eq("b_sg", 32'(ifb.startGet), 32'd1);
        check_eq("b_xy", 32'({ifb.xCenter, ifb.yCenter}), 32'({8'd1, 8'd1}));
        @(negedge clk);
        ifb.windowOut = 1'b1;
        repeat (9) @(negedge clk);
        ifb.windowOut = 1'b0;
        check_eq("b_ms", 32'(ifb.medianStart), 32'd1);
        @(negedge clk);
        ifb.medianDone = 1'b1;
        @(negedge clk);
        ifb.medianDone = 1'b0;
        check_eq("b_wv", 32'(ifb.wrValid), 32'd1);
        ifb.wrReady = 1'b1;
        @(negedge clk);
        ifb.wrReady = 1'b0;
        check_eq("b_next_wv", 32'(ifb.wrValid), 32'd0);
        check_eq("b_next_fd", 32'(ifb.frameDone), 32'd0);
        @(negedge clk);
        check_eq("b_done_fd", 32'(ifb.frameDone), 32'd1);
        check_eq("b_done_sg", 32'(ifb.startGet), 32'd0);
        @(negedge clk);
        check_eq("b_idle_busy", 32'(ifb.busy), 32'd0);
        check_eq("b_idle_fd", 32'(ifb.frameDone), 32'd0);
        check_eq("b_idle_xy", 32'({ifb.xCenter, ifb.yCenter}), 32'({8'd1, 8'd1}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
